// File: rtl/lpif_pkg.sv
// Shared LPIF definitions: beat width, marker-set selection and packet state.
// Used by the TX packer and the RX-side unpacker.
package lpif_pkg;

    localparam int LP_BYTES = 64;

    // Which start/end marker pair a packet drives.
    typedef enum logic {
        MSET_TLP  = 1'b0,
        MSET_DLLP = 1'b1
    } mset_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    // One full LPIF beat: payload, per-byte valid and the four marker vectors.
    typedef struct packed {
        logic [8*LP_BYTES-1:0] data;
        logic [LP_BYTES-1:0]   valid;
        logic [LP_BYTES-1:0]   tlpstart;
        logic [LP_BYTES-1:0]   tlpend;
        logic [LP_BYTES-1:0]   dlpstart;
        logic [LP_BYTES-1:0]   dlpend;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/lpif_beat_reg.sv
// Output holding register for one LPIF beat.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, clears the beat to zero
//   load_i   capture beat_i (only issued when free_o is high)
//   hold_i   downstream full; the presented beat is held while high
//   beat_i   beat to capture
//   valid_o  a beat is presented
//   free_o   register is empty or its beat transfers this cycle
//   beat_o   presented beat (all zero when nothing is presented)
module lpif_beat_reg #(
    parameter int W = lpif_pkg::BEAT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         hold_i,
    input  logic [W-1:0] beat_i,
    output logic         valid_o,
    output logic         free_o,
    output logic [W-1:0] beat_o
);

    logic         valid_q;
    logic [W-1:0] beat_q;

    assign free_o  = !valid_q || !hold_i;
    assign valid_o = valid_q;
    assign beat_o  = beat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            beat_q  <= beat_i;
        end else if (valid_q && !hold_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end
    end

endmodule

// File: rtl/lpif_tx_packer.sv
// Packs a narrow TLP/DLLP word stream into full-width LPIF transmit beats.
// Every packet starts at byte 0 of a fresh beat. One beat assembles while one
// is presented; a completed beat that cannot be presented is parked and input
// stalls until the presented beat drains.
// Ports:
//   pclk, reset       clock, synchronous active-high reset
//   in_valid/in_ready input word handshake
//   in_data/in_bytes  word payload (byte 0 in [7:0]) and valid byte count
//   in_sop/in_eop     first / last word of packet; in_is_dllp type on sop
//   lp_irdy           beat presented; transfers when lp_irdy & !pl_trdy
//   pl_trdy           PHY FIFO full
//   lp_data/lp_valid  beat payload and per-byte valid
//   lp_tlp*/lp_dlp*   per-byte start/end markers
//   proto_err         sticky protocol-violation flag
module lpif_tx_packer #(
    parameter int IN_BYTES = 8,
    parameter int LP_BYTES = lpif_pkg::LP_BYTES
) (
    input  logic                          pclk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*IN_BYTES-1:0]         in_data,
    input  logic [$clog2(IN_BYTES):0]     in_bytes,
    input  logic                          in_sop,
    input  logic                          in_eop,
    input  logic                          in_is_dllp,
    output logic                          lp_irdy,
    input  logic                          pl_trdy,
    output logic [8*LP_BYTES-1:0]         lp_data,
    output logic [LP_BYTES-1:0]           lp_valid,
    output logic [LP_BYTES-1:0]           lp_tlpstart,
    output logic [LP_BYTES-1:0]           lp_tlpend,
    output logic [LP_BYTES-1:0]           lp_dlpstart,
    output logic [LP_BYTES-1:0]           lp_dlpend,
    output logic                          proto_err
);

    import lpif_pkg::*;

    localparam int WORDS = LP_BYTES / IN_BYTES;
    localparam int WPW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int NBW   = $clog2(IN_BYTES) + 1;
    localparam int BIW   = $clog2(LP_BYTES);
    localparam int IBW   = $clog2(8 * IN_BYTES);
    localparam logic [WPW-1:0] WP_LAST = WPW'(WORDS - 1);

    logic                  reset_q;
    beat_t                 acc_q, acc_d;
    logic [WPW-1:0]        wp_q, wp_d;
    pkt_state_e            state_q, state_d;
    mset_e                 mset_q, mset_d;
    logic                  acc_full_q, acc_full_d;
    logic                  err_q, err_d;
    // Sop word that arrived mid-packet while the beat it closed had to park.
    logic                  pend_q, pend_d;
    logic [8*IN_BYTES-1:0] pend_data_q, pend_data_d;
    logic [NBW-1:0]        pend_nb_q, pend_nb_d;
    logic                  pend_eop_q, pend_eop_d;
    mset_e                 pend_mset_q, pend_mset_d;

    logic                  accept;
    logic                  word_err;
    logic [NBW-1:0]        nb_eff;
    mset_e                 word_mset;
    mset_e                 cur_mset;
    beat_t                 merged_cur, merged_new, merged_pend;
    logic                  load;
    beat_t                 load_beat;
    logic                  out_free;
    logic                  out_valid;
    logic [BEAT_W-1:0]     out_vec;
    beat_t                 out_beat;

    function automatic beat_t merge_word(
        input beat_t                 acc,
        input logic [WPW-1:0]        wp,
        input logic [8*IN_BYTES-1:0] d,
        input logic [NBW-1:0]        nb,
        input logic                  sop,
        input logic                  eop,
        input mset_e                 ms
    );
        beat_t          b;
        logic [BIW-1:0] base;
        logic [BIW-1:0] idx;
        logic [IBW-1:0] dsel;
        b    = acc;
        base = BIW'(wp) * BIW'(IN_BYTES);
        for (int unsigned i = 0; i < IN_BYTES; i++) begin
            if (i < 32'(nb)) begin
                idx  = base + BIW'(i);
                dsel = IBW'(8 * i);
                b.data[{idx, 3'b000} +: 8] = d[dsel +: 8];
                b.valid[idx] = 1'b1;
            end
        end
        if (sop) begin
            if (ms == MSET_DLLP) b.dlpstart[0] = 1'b1;
            else                 b.tlpstart[0] = 1'b1;
        end
        if (eop) begin
            idx = base + BIW'(nb - NBW'(1));
            if (ms == MSET_DLLP) b.dlpend[idx] = 1'b1;
            else                 b.tlpend[idx] = 1'b1;
        end
        return b;
    endfunction

    assign in_ready  = !reset_q && !acc_full_q;
    assign accept    = in_valid && in_ready;
    assign word_mset = in_is_dllp ? MSET_DLLP : MSET_TLP;
    assign cur_mset  = in_sop ? word_mset : mset_q;

    // Byte-count sanitising: zero counts as one, short non-eop words as full.
    always_comb begin
        nb_eff   = in_bytes;
        word_err = 1'b0;
        if (in_bytes == '0) begin
            nb_eff   = NBW'(1);
            word_err = 1'b1;
        end else if ((!in_eop && in_bytes != NBW'(IN_BYTES)) || in_bytes > NBW'(IN_BYTES)) begin
            nb_eff   = NBW'(IN_BYTES);
            word_err = 1'b1;
        end
    end

    assign merged_cur  = merge_word(acc_q, wp_q, in_data, nb_eff, in_sop, in_eop, cur_mset);
    assign merged_new  = merge_word('0, '0, in_data, nb_eff, 1'b1, in_eop, word_mset);
    assign merged_pend = merge_word('0, '0, pend_data_q, pend_nb_q, 1'b1, pend_eop_q, pend_mset_q);

    always_comb begin
        acc_d       = acc_q;
        wp_d        = wp_q;
        state_d     = state_q;
        mset_d      = mset_q;
        acc_full_d  = acc_full_q;
        err_d       = err_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_nb_d   = pend_nb_q;
        pend_eop_d  = pend_eop_q;
        pend_mset_d = pend_mset_q;
        load        = 1'b0;
        load_beat   = '0;

        if (acc_full_q) begin
            if (out_free) begin
                load       = 1'b1;
                load_beat  = acc_q;
                acc_full_d = 1'b0;
                acc_d      = '0;
                wp_d       = '0;
                // A held restart word opens the fresh beat; if it completes
                // the beat on its own it parks again behind the one just loaded.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = pend_eop_q ? ST_IDLE : ST_IN_PKT;
                    mset_d  = pend_mset_q;
                    acc_d   = merged_pend;
                    if (pend_eop_q || WP_LAST == '0) acc_full_d = 1'b1;
                    else                             wp_d = WPW'(1);
                end
            end
        end else if (accept) begin
            err_d = err_q | word_err;
            if (state_q == ST_IDLE && !in_sop) begin
                err_d = 1'b1;
            end else if (state_q == ST_IN_PKT && in_sop && wp_q != '0) begin
                // Close the open beat as-is; the sop word starts the next beat.
                err_d = 1'b1;
                if (out_free) begin
                    load      = 1'b1;
                    load_beat = acc_q;
                    state_d   = in_eop ? ST_IDLE : ST_IN_PKT;
                    mset_d    = word_mset;
                    acc_d     = merged_new;
                    if (in_eop || WP_LAST == '0) begin
                        acc_full_d = 1'b1;
                        wp_d       = '0;
                    end else begin
                        wp_d = WPW'(1);
                    end
                end else begin
                    acc_full_d  = 1'b1;
                    wp_d        = '0;
                    pend_d      = 1'b1;
                    pend_data_d = in_data;
                    pend_nb_d   = nb_eff;
                    pend_eop_d  = in_eop;
                    pend_mset_d = word_mset;
                end
            end else begin
                if (state_q == ST_IN_PKT && in_sop) err_d = 1'b1;
                if (in_sop) mset_d = word_mset;
                state_d = in_eop ? ST_IDLE : ST_IN_PKT;
                if (in_eop || wp_q == WP_LAST) begin
                    wp_d = '0;
                    if (out_free) begin
                        load      = 1'b1;
                        load_beat = merged_cur;
                        acc_d     = '0;
                    end else begin
                        acc_d      = merged_cur;
                        acc_full_d = 1'b1;
                    end
                end else begin
                    acc_d = merged_cur;
                    wp_d  = wp_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        reset_q <= reset;
        if (reset) begin
            acc_q       <= '0;
            wp_q        <= '0;
            state_q     <= ST_IDLE;
            mset_q      <= MSET_TLP;
            acc_full_q  <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_nb_q   <= '0;
            pend_eop_q  <= 1'b0;
            pend_mset_q <= MSET_TLP;
        end else begin
            acc_q       <= acc_d;
            wp_q        <= wp_d;
            state_q     <= state_d;
            mset_q      <= mset_d;
            acc_full_q  <= acc_full_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_nb_q   <= pend_nb_d;
            pend_eop_q  <= pend_eop_d;
            pend_mset_q <= pend_mset_d;
        end
    end

    lpif_beat_reg #(
        .W (BEAT_W)
    ) u_beat_reg (
        .clk_i   (pclk),
        .rst_i   (reset),
        .load_i  (load),
        .hold_i  (pl_trdy),
        .beat_i  (load_beat),
        .valid_o (out_valid),
        .free_o  (out_free),
        .beat_o  (out_vec)
    );

    assign out_beat    = beat_t'(out_vec);
    assign lp_irdy     = out_valid;
    assign lp_data     = out_beat.data;
    assign lp_valid    = out_beat.valid;
    assign lp_tlpstart = out_beat.tlpstart;
    assign lp_tlpend   = out_beat.tlpend;
    assign lp_dlpstart = out_beat.dlpstart;
    assign lp_dlpend   = out_beat.dlpend;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_lpif_tx_packer.sv
module tb_lpif_tx_packer;
    import lpif_pkg::*;

    logic         pclk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic [3:0]   in_bytes;
    logic         in_sop;
    logic         in_eop;
    logic         in_is_dllp;
    logic         lp_irdy;
    logic         pl_trdy;
    logic [511:0] lp_data;
    logic [63:0]  lp_valid;
    logic [63:0]  lp_tlpstart;
    logic [63:0]  lp_tlpend;
    logic [63:0]  lp_dlpstart;
    logic [63:0]  lp_dlpend;
    logic         proto_err;

    int    total = 0;
    int    bad = 0;
    int    stall_cnt = 0;
    int    beat_no = 0;
    beat_t expq[$];

    lpif_tx_packer #(
        .IN_BYTES (8),
        .LP_BYTES (64)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_bytes    (in_bytes),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_is_dllp  (in_is_dllp),
        .lp_irdy     (lp_irdy),
        .pl_trdy     (pl_trdy),
        .lp_data     (lp_data),
        .lp_valid    (lp_valid),
        .lp_tlpstart (lp_tlpstart),
        .lp_tlpend   (lp_tlpend),
        .lp_dlpstart (lp_dlpstart),
        .lp_dlpend   (lp_dlpend),
        .proto_err   (proto_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input int p, input int k);
        return 8'((p * 37 + k * 3 + 1) & 255);
    endfunction

    function automatic logic [63:0] mkword(input int p, input int off, input int nb);
        logic [63:0] d;
        d = '0;
        for (int b = 0; b < 8; b++)
            if (b < nb) d[8*b +: 8] = pat(p, off + b);
        return d;
    endfunction

    // Expected beat: nvalid bytes of packet p starting at packet offset off.
    function automatic beat_t exp_beat(input int p, input int off, input int nvalid,
                                       input logic sop, input logic eop, input logic dllp);
        beat_t e;
        e = '0;
        for (int i = 0; i < nvalid; i++) begin
            e.data[8*i +: 8] = pat(p, off + i);
            e.valid[i] = 1'b1;
        end
        if (sop) begin
            if (dllp) e.dlpstart[0] = 1'b1;
            else      e.tlpstart[0] = 1'b1;
        end
        if (eop) begin
            if (dllp) e.dlpend[nvalid-1] = 1'b1;
            else      e.tlpend[nvalid-1] = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a beat transfers on the next rising edge when irdy & !trdy.
    always @(negedge pclk) begin : monitor
        beat_t e;
        if (!reset && lp_irdy && !pl_trdy) begin
            beat_no++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat%0d unexpected: got valid %h expected no beat", beat_no, lp_valid);
            end else begin
                e = expq.pop_front();
                chkw($sformatf("beat%0d.data", beat_no), lp_data, e.data);
                chk($sformatf("beat%0d.valid", beat_no), lp_valid, e.valid);
                chk($sformatf("beat%0d.tlpstart", beat_no), lp_tlpstart, e.tlpstart);
                chk($sformatf("beat%0d.tlpend", beat_no), lp_tlpend, e.tlpend);
                chk($sformatf("beat%0d.dlpstart", beat_no), lp_dlpstart, e.dlpstart);
                chk($sformatf("beat%0d.dlpend", beat_no), lp_dlpend, e.dlpend);
            end
        end
    end

    // Presents one word and returns #1 after the edge that accepted it.
    task automatic send_word(input logic [63:0] d, input logic [3:0] nb,
                             input logic sop, input logic eop, input logic dllp);
        int waited;
        waited     = 0;
        in_valid   = 1'b1;
        in_data    = d;
        in_bytes   = nb;
        in_sop     = sop;
        in_eop     = eop;
        in_is_dllp = dllp;
        while (!in_ready && waited < 100) begin
            @(posedge pclk);
            #1;
            waited++;
        end
        stall_cnt += waited;
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic send_pkt(input int p, input int nbytes, input logic dllp);
        int nw;
        int nb;
        nw = (nbytes + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            nb = (nbytes - w * 8 > 8) ? 8 : nbytes - w * 8;
            send_word(mkword(p, w * 8, nb), 4'(nb), w == 0, w == nw - 1, dllp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_bytes   = '0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_is_dllp = 1'b0;
        pl_trdy    = 1'b0;

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_irdy", lp_irdy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", lp_valid, 0);
        chkw("rst_data", lp_data, '0);
        chk("rst_markers", lp_tlpstart | lp_tlpend | lp_dlpstart | lp_dlpend, 0);
        chk("rst_proto_err", proto_err, 0);
        reset = 1'b0;
        @(posedge pclk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // 24-byte TLP, one beat one cycle after the eop word
        expq.push_back(exp_beat(1, 0, 24, 1, 1, 0));
        send_pkt(1, 24, 0);
        chk("t1_latency_irdy", lp_irdy, 1);
        chk("t1_valid", lp_valid, 64'h0000_0000_00FF_FFFF);
        chk("t1_tlpend23", lp_tlpend[23], 1);
        idle(3);

        // 128-byte TLP, two beats, no input bubble
        stall_cnt = 0;
        expq.push_back(exp_beat(2, 0, 64, 1, 0, 0));
        expq.push_back(exp_beat(2, 64, 64, 0, 1, 0));
        send_pkt(2, 128, 0);
        chk("t2_no_bubble", 64'(stall_cnt), 0);

        // 6-byte DLLP in one word, issued straight after the TLP
        expq.push_back(exp_beat(3, 0, 6, 1, 1, 1));
        send_pkt(3, 6, 1);
        chk("t3_valid", lp_valid, 64'h3F);
        chk("t3_dlpstart", lp_dlpstart, 64'h1);
        chk("t3_dlpend", lp_dlpend, 64'h20);
        chk("t3_no_tlp", lp_tlpstart | lp_tlpend, 0);
        idle(3);

        // pl_trdy high for 20 cycles during a 3-beat packet
        pl_trdy = 1'b1;
        expq.push_back(exp_beat(4, 0, 64, 1, 0, 0));
        expq.push_back(exp_beat(4, 64, 64, 0, 0, 0));
        expq.push_back(exp_beat(4, 128, 64, 0, 1, 0));
        fork
            send_pkt(4, 192, 0);
            begin
                repeat (12) @(posedge pclk);
                #1;
                chkw("t4_held_data_c12", lp_data, exp_beat(4, 0, 64, 1, 0, 0).data);
                repeat (8) @(posedge pclk);
                #1;
                chk("t4_in_ready_stalled", in_ready, 0);
                chk("t4_irdy_held", lp_irdy, 1);
                chkw("t4_held_data_c20", lp_data, exp_beat(4, 0, 64, 1, 0, 0).data);
                chk("t4_held_tlpstart", lp_tlpstart, 64'h1);
                pl_trdy = 1'b0;
            end
        join
        idle(4);

        // Protocol errors: stray non-sop word, then sop inside a packet
        send_word(mkword(99, 0, 8), 4'd8, 1'b0, 1'b0, 1'b0);
        chk("t5_err_idle_word", proto_err, 1);
        expq.push_back(exp_beat(5, 0, 16, 1, 0, 0));
        expq.push_back(exp_beat(6, 0, 8, 1, 1, 0));
        send_word(mkword(5, 0, 8), 4'd8, 1'b1, 1'b0, 1'b0);
        send_word(mkword(5, 8, 8), 4'd8, 1'b0, 1'b0, 1'b0);
        send_pkt(6, 8, 0);
        idle(4);
        chk("t5_err_sticky", proto_err, 1);

        // Reset mid-packet with a presented beat
        pl_trdy = 1'b1;
        send_pkt(7, 8, 0);
        send_word(mkword(8, 0, 8), 4'd8, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("t6_irdy_before_rst", lp_irdy, 1);
        reset = 1'b1;
        @(posedge pclk);
        #1;
        chk("t6_irdy_cleared", lp_irdy, 0);
        chk("t6_valid_cleared", lp_valid, 0);
        chkw("t6_data_cleared", lp_data, '0);
        chk("t6_markers_cleared", lp_tlpstart | lp_tlpend | lp_dlpstart | lp_dlpend, 0);
        chk("t6_err_cleared", proto_err, 0);
        chk("t6_in_ready_low", in_ready, 0);
        reset   = 1'b0;
        pl_trdy = 1'b0;
        @(posedge pclk);
        #1;
        expq.push_back(exp_beat(9, 0, 16, 1, 1, 0));
        send_pkt(9, 16, 0);
        in_valid = 1'b0;

        for (int i = 0; i < 50 && expq.size() != 0; i++) begin
            @(posedge pclk);
            #1;
        end
        repeat (2) @(posedge pclk);
        #1;
        chk("sb_drained", 64'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpif_tx_packer.md
# lpif_tx_packer

Link-layer-side packer that turns a narrow stream of TLP/DLLP words into full-width LPIF transmit beats (`lp_data`, `lp_valid`, `lp_tlpstart`/`lp_tlpend`, `lp_dlpstart`/`lp_dlpend`, `lp_irdy`). It sits directly upstream of the PCIe TX physical-layer top and drives its LPIF inputs. It honours that block's back-pressure on `pl_trdy`, which is high when the TX control FIFO is full. Each packet starts at byte 0 of a fresh beat; the block holds one beat in assembly and one beat presented to the PHY.

## Interface
- `IN_BYTES`, 8, bytes per input word; power of two, divides `LP_BYTES`
- `LP_BYTES`, 64, bytes per LPIF beat; fixed by the 512-bit LPIF bus
- `pclk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input word present
- `in_ready`  out  1  packer accepts word this cycle
- `in_data`  in  8*IN_BYTES  payload, byte 0 in bits [7:0]
- `in_bytes`  in  $clog2(IN_BYTES)+1  valid byte count, 1..IN_BYTES
- `in_sop` / `in_eop`  in  1 each  first / last word of packet
- `in_is_dllp`  in  1  packet type, sampled on the sop word
- `lp_irdy`  out  1  beat valid
- `pl_trdy`  in  1  PHY FIFO full; beat transfers when `lp_irdy & !pl_trdy`
- `lp_data`  out  8*LP_BYTES  beat payload
- `lp_valid`  out  LP_BYTES  per-byte valid
- `lp_tlpstart`, `lp_tlpend`, `lp_dlpstart`, `lp_dlpend`  out  LP_BYTES each  per-byte markers
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- Accumulator: write pointer `wp` counts 0..LP_BYTES/IN_BYTES-1 words. An accepted word is written at byte offset `wp*IN_BYTES`, and `lp_valid` bits are set for its first `in_bytes` bytes.
- Packet state: IDLE or IN_PKT. The sop word sets a start marker on byte 0 of the current beat and latches the type: `in_is_dllp` selects the dlp marker set, otherwise the tlp marker set. The eop word sets the end marker on its last valid byte.
- Beat completion occurs when the accepted word fills the last slot or carries eop. The completed beat (accumulator plus this word) goes straight to the output register if that register is empty or drains this cycle. Otherwise it is parked (`acc_full`=1) and `in_ready`=0.
- `in_ready = !reset_q & !acc_full`.
- When the output register drains and `acc_full`=1:
  - The parked beat moves to the output register.
  - The accumulator clears and `wp`=0.
  - `in_ready` rises the next cycle.
- Unwritten bytes: data, valid and all markers are 0.
- `proto_err` is set, and held until reset, on any of the following:
  - non-sop word in IDLE: word dropped;
  - sop in IN_PKT: current beat closed without end marker, new packet starts in the next beat;
  - non-eop word with `in_bytes != IN_BYTES`: treated as full;
  - `in_bytes`=0: treated as 1.
- Single-word packet (sop & eop together): start and end markers are set in the same beat.

## Timing
- Reset values: `lp_irdy`=0, `lp_data`/`lp_valid`/all markers 0, `in_ready`=0, `proto_err`=0, state IDLE, `wp`=0. `in_ready` is 1 from the first cycle after reset deasserts.
- Reset asserted mid-packet discards both the assembling and the presented beat. No partial beat is emitted.
- Latency: completing word accepted in cycle N gives `lp_irdy`=1 in cycle N+1 when the output register is free.
- While `lp_irdy & pl_trdy`, all `lp_*` outputs hold stable.
- Throughput: one beat per LP_BYTES/IN_BYTES cycles sustained. A simultaneous drain and completion costs no bubble.
- `pl_trdy` stuck high: at most one presented beat plus one parked beat are held; input then stalls.

## Structure
- Package `lpif_pkg`: `LP_BYTES`, marker-set enum (TLP/DLLP), packet state enum. It is shared with the future RX-side unpacker.
- Sub-module `lpif_beat_reg`: output holding register with load/drain handshake and stability guarantee. The packer instantiates one.

## Test plan
- 24-byte TLP, `IN_BYTES`=8, `pl_trdy`=0 -> one beat, `lp_valid[23:0]` set, `tlpstart[0]`=1, `tlpend[23]`=1, `lp_irdy` one cycle after the eop word.
- 128-byte TLP -> two beats, `tlpstart[0]` only in beat 1, `tlpend[63]` only in beat 2, no input bubble.
- 6-byte DLLP in one word (sop & eop, `in_bytes`=6) -> `dlpstart[0]`=1, `dlpend[5]`=1, `lp_valid`=0x3F, no tlp markers.
- `pl_trdy` held high for 20 cycles during a 3-beat packet -> beat 1 stable, beat 2 parked, `in_ready`=0. Release gives beats in order with no loss or duplication.
- Non-sop word in IDLE, then sop during IN_PKT -> `proto_err`=1 and stays 1. First word dropped; open beat closed without end marker.
- Reset asserted mid-packet with `lp_irdy`=1 -> next cycle `lp_irdy`=0 and all outputs 0. The following packet starts at byte 0.
